// File: rtl/arc4_engine.sv
// rtl/arc4_engine.sv - ARC4 decrypt engine: S init, KSA, PRGA over external S/ct/pt memories.
// Optional plaintext-printable flag enabled by defining ARC4_VALID_CHECK_EN.
module arc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic [MSG_AW-1:0]      ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [MSG_AW-1:0]      pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren,
  output logic                   key_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT,
    S_KSA_RI, S_KSA_RJ, S_KSA_WI, S_KSA_WJ,
    S_LEN_RD, S_LEN_WR,
    S_PRGA_RI, S_PRGA_RJ, S_PRGA_WI, S_PRGA_WJ, S_PRGA_RP, S_PRGA_WR,
    S_DONE
  } state_t;

  state_t                 r_state, w_next;
  logic [7:0]             r_i, r_j, r_si, r_sj, r_ct, r_len;
  logic [MSG_AW-1:0]      r_k;
  logic [KEY_BYTES*8-1:0] r_key;

  logic [7:0] w_key_byte, w_j_ksa, w_j_prga, w_pt_byte;
  logic       w_start, w_last;

  // Key register rotates one byte per KSA step, so its top byte is always key[i mod KEY_BYTES].
  assign w_key_byte = r_key[KEY_BYTES*8-1 -: 8];
  assign w_j_ksa    = r_j + s_rddata + w_key_byte;
  assign w_j_prga   = r_j + s_rddata;
  assign w_pt_byte  = s_rddata ^ r_ct;
  assign w_start    = rdy & en;
  assign w_last     = (r_k == MSG_AW'(r_len));

  always_comb begin
    w_next    = r_state;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (r_state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) w_next = S_INIT;
      end
      S_INIT: begin
        s_addr   = r_i;
        s_wrdata = r_i;
        s_wren   = 1'b1;
        if (r_i == 8'hff) w_next = S_KSA_RI;
      end
      S_KSA_RI: begin
        s_addr = r_i;
        w_next = S_KSA_RJ;
      end
      S_KSA_RJ: begin
        s_addr = w_j_ksa;
        w_next = S_KSA_WI;
      end
      S_KSA_WI: begin
        s_addr   = r_i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        w_next   = S_KSA_WJ;
      end
      S_KSA_WJ: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
        w_next   = (r_i == 8'hff) ? S_LEN_RD : S_KSA_RI;
      end
      S_LEN_RD: w_next = S_LEN_WR;
      S_LEN_WR: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        w_next    = (ct_rddata == 8'd0) ? S_DONE : S_PRGA_RI;
      end
      S_PRGA_RI: begin
        s_addr  = r_i + 8'd1;
        ct_addr = r_k;
        w_next  = S_PRGA_RJ;
      end
      S_PRGA_RJ: begin
        s_addr = w_j_prga;
        w_next = S_PRGA_WI;
      end
      S_PRGA_WI: begin
        s_addr   = r_i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        w_next   = S_PRGA_WJ;
      end
      S_PRGA_WJ: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
        w_next   = S_PRGA_RP;
      end
      S_PRGA_RP: begin
        s_addr = r_si + r_sj;
        w_next = S_PRGA_WR;
      end
      S_PRGA_WR: begin
        pt_addr   = r_k;
        pt_wrdata = w_pt_byte;
        pt_wren   = 1'b1;
        w_next    = w_last ? S_DONE : S_PRGA_RI;
      end
      S_DONE: begin
        rdy    = 1'b1;
        w_next = en ? S_INIT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_ct    <= 8'd0;
      r_len   <= 8'd0;
      r_k     <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (en) begin
            r_key <= key;
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_k   <= '0;
          end
        end
        S_INIT: r_i <= r_i + 8'd1;
        S_KSA_RJ: begin
          r_si <= s_rddata;
          r_j  <= w_j_ksa;
        end
        S_KSA_WJ: begin
          r_i   <= r_i + 8'd1;
          r_key <= (r_key << 8) | (r_key >> (KEY_BYTES*8-8));
        end
        S_LEN_WR: begin
          r_len <= ct_rddata;
          r_i   <= 8'd0;
          r_j   <= 8'd0;
          r_k   <= MSG_AW'(1);
        end
        S_PRGA_RI: r_i <= r_i + 8'd1;
        S_PRGA_RJ: begin
          r_si <= s_rddata;
          r_j  <= w_j_prga;
          r_ct <= ct_rddata;
        end
        S_PRGA_WI: r_sj <= s_rddata;
        S_PRGA_WR: r_k <= r_k + MSG_AW'(1);
        default: ;
      endcase
    end
  end

`ifdef ARC4_VALID_CHECK_EN
  logic r_fail, r_key_valid, w_bad;

  assign w_bad     = (w_pt_byte < 8'h20) || (w_pt_byte > 8'h7e);
  assign key_valid = r_key_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail      <= 1'b0;
      r_key_valid <= 1'b0;
    end else if (w_start) begin
      r_fail      <= 1'b0;
      r_key_valid <= 1'b0;
    end else if (r_state == S_LEN_WR && ct_rddata == 8'd0) begin
      r_key_valid <= 1'b1;
    end else if (r_state == S_PRGA_WR) begin
      r_fail <= r_fail | w_bad;
      if (w_last) r_key_valid <= ~(r_fail | w_bad);
    end
  end
`else
  assign key_valid = 1'b0;
`endif

endmodule

// File: doc/arc4_engine.md
Name: arc4_engine

Overview:
Parametrised ARC4 decryption engine, the next generation of the fixed 24-bit-key ARC4 core used by the switch-keyed decrypt top level. Key length is generalised to KEY_BYTES bytes. The engine runs S-box init, KSA and PRGA against an external 256x8 S memory, reads a length-prefixed ciphertext memory, and writes the length-prefixed plaintext memory. It is the unit a brute-force key-search controller instantiates, so it adds a restart-safe ready/enable handshake and an optional plaintext-validity flag.

Parameters:
KEY_BYTES, 3, key length in bytes (1..32); key byte 0 = most significant byte of key port
MSG_AW, 8, address width of ct/pt memories; max message length 2**MSG_AW-1 bytes

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  start request, honoured only while rdy=1
rdy  output  1  idle/ready for new start
key  input  KEY_BYTES*8  ARC4 key, latched at start
s_addr  output  8  S memory address
s_rddata  input  8  S memory read data, 1-cycle synchronous read
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write enable
ct_addr  output  MSG_AW  ciphertext address
ct_rddata  input  8  ciphertext read data, 1-cycle synchronous read
pt_addr  output  MSG_AW  plaintext address
pt_wrdata  output  8  plaintext write data
pt_wren  output  1  plaintext write enable
key_valid  output  1  plaintext all-printable flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; rdy=1; s_wren=0; pt_wren=0; all address/data outputs 0; key_valid=0; internal i, j, k, length and key registers cleared. Reset mid-operation aborts immediately; memory contents are then undefined.
- Handshake: en sampled on a rising clk with rdy=1 starts a run. rdy falls the next cycle and stays 0 until the run ends. en while rdy=0 is ignored. rdy rises the cycle after the last pt write. en held high continuously starts back-to-back runs, with exactly one rdy=1 cycle between them.
- key is latched into an internal register at start; later key changes do not affect the run.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
- INIT: writes s[i]=i for i=0..255, one write per cycle (256 cycles).
- KSA: for i=0..255:
  - j = (j + s[i] + keybyte[i mod KEY_BYTES]) mod 256; j starts at 0.
  - Swap s[i] and s[j]; when i==j the swap writes the same value back, with no corruption.
  - All sums are 8-bit wraparound.
- LEN: read ct[0] = L; write pt[0] = L.
  - L=0: go straight to DONE with no PRGA reads or writes.
- PRGA: i=j=0; for k=1..L:
  - i = i+1; j = j + s[i]; swap s[i], s[j].
  - pad = s[(s[i]+s[j]) mod 256].
  - pt[k] = pad XOR ct[k].
- Every read waits its one-cycle latency. No S read in a cycle that writes the same address. Exactly one pt write per byte, addresses strictly increasing.
- At most one s_wren/pt_wren pulse per cycle. Write enables are deasserted in IDLE and DONE.
- Per-step cycle count is left to the implementation. It must not exceed 8 cycles per KSA/PRGA byte.

Optional Feature:
ARC4_VALID_CHECK_EN
- Defined:
  - key_valid clears to 0 at start.
  - At DONE it is set to 1 iff every plaintext byte pt[1..L] lay in 0x20..0x7E.
  - Tracked on the fly with a sticky fail bit, without re-reading pt.
  - L=0 gives key_valid=1.
  - key_valid holds until the next start or reset.
- Undefined: key_valid is tied to 0 and the check logic is absent.

Test Plan:
- RFC 6229 vector: KEY_BYTES=5, key=40'h0102030405, ct = {8, 00 x8} -> pt = {08, b2 39 63 05 f0 3d c0 27}; rdy returns to 1.
- Default KEY_BYTES=3, key=24'h000018, 50-byte random ct -> pt matches the bench software ARC4 model byte-for-byte; final S memory matches the model.
- L=0 (ct[0]=00) -> exactly one pt write (pt[0]=00); no PRGA; with ARC4_VALID_CHECK_EN, key_valid=1.
- Handshake:
  - Pulse en while busy -> ignored; one run only.
  - en held high across 2 runs with a key change during run 1 -> run 1 uses the latched key; run 2 starts after a single rdy=1 cycle.
- Assert rst_n=0 mid-KSA -> same cycle: rdy=1, s_wren=pt_wren=0. Then restart with en -> correct result for the RFC vector.
- ARC4_VALID_CHECK_EN defined:
  - Encrypted "HELLO" -> key_valid=1.
  - Ciphertext whose plaintext contains 0x0A -> key_valid=0.
  - Macro undefined -> key_valid stays 0.
